// File: rtl/chnl_pkg.sv
// Shared constants for the RIFFA channel path: word/length/offset widths and
// the encoding of the RX channel state machine.
package chnl_pkg;

  localparam int WORD_W      = 32;
  localparam int RIFFA_LEN_W = 32;
  localparam int RIFFA_OFF_W = 31;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  // Words consumed from the remaining count by one beat of wpb words.
  function automatic logic [RIFFA_LEN_W-1:0] words_taken(
    input logic [RIFFA_LEN_W-1:0] rem,
    input int                     wpb
  );
    return (rem <= RIFFA_LEN_W'(wpb)) ? rem : RIFFA_LEN_W'(wpb);
  endfunction

endpackage

// File: rtl/chnl_skid_buffer.sv
// Two-entry FIFO decoupling a valid/ready producer from its consumer.
// Ready is taken from the registered occupancy so it never depends on out_rdy.
module chnl_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_rdy   = (count_q != 2'd2);
  assign out_val  = (count_q != 2'd0);
  assign out_data = mem_q[rd_ptr_q];
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_chnl_unpacker.sv
// Terminates one RIFFA RX channel and turns each transfer into a valid/ready
// beat stream, zero-filling words past the transfer length on the final beat.
//
// state  | meaning
// IDLE   | waiting for CHNL_RX
// ACK    | acknowledging the new transfer for one cycle
// DATA   | accepting beats until the remaining word count runs out
// WAIT   | transfer done, waiting for CHNL_RX to drop
module rx_chnl_unpacker
  import chnl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   CHNL_RX_CLK,
  input  logic                   CHNL_RX,
  output logic                   CHNL_RX_ACK,
  input  logic                   CHNL_RX_LAST,
  input  logic [RIFFA_LEN_W-1:0] CHNL_RX_LEN,
  input  logic [RIFFA_OFF_W-1:0] CHNL_RX_OFF,
  input  logic [DW-1:0]          CHNL_RX_DATA,
  input  logic                   CHNL_RX_DATA_VALID,
  output logic                   CHNL_RX_DATA_REN,
  output logic                   o_val,
  input  logic                   o_rdy,
  output logic [DW-1:0]          o_data,
  output logic                   o_last,
  output logic                   o_abort,
  output logic                   o_busy
);

  localparam int WPB = DW / WORD_W;

  logic [1:0]             state_q, state_d;
  logic [RIFFA_LEN_W-1:0] rem_q, rem_d;
  logic                   abort_q, abort_d;
  logic                   skid_in_rdy, skid_in_val;
  logic                   last_beat;
  logic [DW-1:0]          masked_data;
  logic [DW:0]            skid_out;
  logic                   unused_ok;

  assign CHNL_RX_CLK = clk;
  assign unused_ok   = ^{CHNL_RX_LAST, CHNL_RX_OFF};

  assign CHNL_RX_ACK      = (state_q == S_ACK);
  assign CHNL_RX_DATA_REN = (state_q == S_DATA) && skid_in_rdy;

  // A drop of CHNL_RX mid-transfer wins over a beat offered in the same cycle.
  assign abort_d     = (state_q == S_DATA) && !CHNL_RX && (rem_q != '0);
  assign skid_in_val = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN && !abort_d;
  assign last_beat   = (rem_q <= RIFFA_LEN_W'(WPB));

  always_comb begin
    masked_data = CHNL_RX_DATA;
    for (int k = 0; k < WPB; k++) begin
      if (RIFFA_LEN_W'(k) >= rem_q) masked_data[k*WORD_W +: WORD_W] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: if (CHNL_RX) begin
        rem_d   = CHNL_RX_LEN;
        state_d = S_ACK;
      end
      S_ACK:  state_d = (rem_q != '0) ? S_DATA : S_WAIT;
      S_DATA: begin
        if (abort_d) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (skid_in_val) begin
          rem_d = rem_q - words_taken(rem_q, WPB);
          if (last_beat) state_d = S_WAIT;
        end
      end
      S_WAIT: if (!CHNL_RX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
    end
  end

  chnl_skid_buffer #(.WIDTH(DW + 1)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (skid_in_val),
    .in_rdy   (skid_in_rdy),
    .in_data  ({last_beat, masked_data}),
    .out_val  (o_val),
    .out_rdy  (o_rdy),
    .out_data (skid_out)
  );

  assign o_data  = skid_out[DW-1:0];
  assign o_last  = skid_out[DW];
  assign o_abort = abort_q;
  assign o_busy  = (state_q != S_IDLE) || o_val;

endmodule

// File: tb/tb_rx_chnl_unpacker.sv
// Directed bench for rx_chnl_unpacker (DW=64): expected beats are queued at
// stimulus time and a negedge monitor pops and compares each delivered beat.
module tb_rx_chnl_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CHNL_RX_CLK;
  logic        CHNL_RX;
  logic        CHNL_RX_ACK;
  logic        CHNL_RX_LAST;
  logic [31:0] CHNL_RX_LEN;
  logic [30:0] CHNL_RX_OFF;
  logic [63:0] CHNL_RX_DATA;
  logic        CHNL_RX_DATA_VALID;
  logic        CHNL_RX_DATA_REN;
  logic        o_val, o_rdy, o_last, o_abort, o_busy;
  logic [63:0] o_data;

  always #5 clk = ~clk;

  rx_chnl_unpacker #(.DW(64)) dut (
    .clk(clk), .rst_n(rst_n), .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX),
    .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN),
    .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
    .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data), .o_last(o_last),
    .o_abort(o_abort), .o_busy(o_busy)
  );

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int ack_cnt = 0, abort_cnt = 0, ren_cnt = 0, last_cnt = 0, n_acc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (CHNL_RX_ACK) ack_cnt++;
      if (o_abort) abort_cnt++;
      if (CHNL_RX_DATA_REN) ren_cnt++;
      if (o_val && o_rdy) begin
        beat_t e;
        n_vec++;
        if (o_last) last_cnt++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got data=%h last=%b, required none", o_data, o_last);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.data || o_last !== e.last) begin
            n_err++;
            $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                     o_data, o_last, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input logic [31:0] base, input int i);
    return base + 32'(17 * (i + 1));
  endfunction

  function automatic logic [63:0] mk_beat(input logic [31:0] base, input int b);
    return {word(base, 2 * b + 1), word(base, 2 * b)};
  endfunction

  function automatic void push_model(input int len, input logic [31:0] base);
    int nb = (len + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e.data[31:0]  = (2 * b < len)     ? word(base, 2 * b)     : 32'h0;
      e.data[63:32] = (2 * b + 1 < len) ? word(base, 2 * b + 1) : 32'h0;
      e.last        = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Presents beats of the transfer until ceil(len/2) of them are accepted.
  task automatic feed(input int len, input logic [31:0] base);
    int nb = (len + 1) / 2;
    int b = 0, cyc = 0;
    logic acc;
    CHNL_RX = 1'b1;
    CHNL_RX_LEN = 32'(len);
    CHNL_RX_DATA_VALID = 1'b1;
    CHNL_RX_DATA = mk_beat(base, 0);
    acc = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
    while (b < nb && cyc < 200) begin
      tick();
      cyc++;
      if (acc) begin
        b++;
        n_acc++;
      end
      CHNL_RX_DATA = mk_beat(base, b);
      acc = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
    end
    if (b < nb) chk("feed_timeout", 64'(b), 64'(nb));
    CHNL_RX_DATA_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || o_val) && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic xfer(input int len, input logic [31:0] base);
    push_model(len, base);
    feed(len, base);
    wait_drain();
    CHNL_RX = 1'b0;
    tick();
  endtask

  initial begin
    int a0, r0, acc0;
    logic acc;
    rst_n = 1'b0;
    CHNL_RX = 1'b0; CHNL_RX_LAST = 1'b0; CHNL_RX_LEN = '0; CHNL_RX_OFF = '0;
    CHNL_RX_DATA = '0; CHNL_RX_DATA_VALID = 1'b0; o_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_o_val", 64'(o_val), 64'd0);
    chk("rst_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
    chk("rst_ack", 64'(CHNL_RX_ACK), 64'd0);
    chk("rst_o_data", o_data, 64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_o_abort", 64'(o_abort), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // LEN=4: ACK timing, two full beats, return to IDLE after CHNL_RX drops
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd4; CHNL_RX_DATA_VALID = 1'b1;
    chk("ack_before", 64'(CHNL_RX_ACK), 64'd0);
    tick();
    chk("ack_pulse", 64'(CHNL_RX_ACK), 64'd1);
    push_model(4, 32'h0A00_0000);
    feed(4, 32'h0A00_0000);
    wait_drain();
    repeat (2) tick();
    chk("wait_busy", 64'(o_busy), 64'd1);
    CHNL_RX = 1'b0;
    tick();
    chk("idle_after_drop", 64'(o_busy), 64'd0);

    // LEN=3: final beat upper word zeroed
    exp_q.push_back('{last: 1'b0, data: 64'h00000022_00000011});
    exp_q.push_back('{last: 1'b1, data: 64'h00000000_00000033});
    feed(3, 32'h0);
    wait_drain();
    CHNL_RX = 1'b0;
    tick();

    // LEN=0: ACK only, no REN, parks in WAIT while CHNL_RX is high
    a0 = ack_cnt; r0 = ren_cnt;
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd0; CHNL_RX_DATA_VALID = 1'b1;
    repeat (6) tick();
    chk("len0_ack_count", 64'(ack_cnt - a0), 64'd1);
    chk("len0_ren_count", 64'(ren_cnt - r0), 64'd0);
    chk("len0_o_val", 64'(o_val), 64'd0);
    chk("len0_wait_busy", 64'(o_busy), 64'd1);
    CHNL_RX = 1'b0; CHNL_RX_DATA_VALID = 1'b0;
    tick();
    chk("len0_idle", 64'(o_busy), 64'd0);

    // LEN=8 with downstream stalled: REN drops at two buffered beats
    o_rdy = 1'b0;
    acc0 = n_acc;
    push_model(8, 32'h1000_0000);
    fork
      feed(8, 32'h1000_0000);
      begin
        int cyc = 0;
        while (n_acc - acc0 < 2 && cyc < 50) begin
          tick();
          cyc++;
        end
        tick();
        chk("stall_ren_low", 64'(CHNL_RX_DATA_REN), 64'd0);
        repeat (4) tick();
        chk("stall_accepts", 64'(n_acc - acc0), 64'd2);
        chk("stall_o_val", 64'(o_val), 64'd1);
        o_rdy = 1'b1;
      end
    join
    wait_drain();
    CHNL_RX = 1'b0;
    tick();

    // LEN=8 aborted after one accepted beat, then a normal LEN=2
    a0 = abort_cnt;
    exp_q.push_back('{last: 1'b0, data: mk_beat(32'h2000_0000, 0)});
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd8; CHNL_RX_DATA_VALID = 1'b1;
    CHNL_RX_DATA = mk_beat(32'h2000_0000, 0);
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;
      tick();
    end
    CHNL_RX = 1'b0; CHNL_RX_DATA_VALID = 1'b0;
    repeat (4) tick();
    chk("abort_pulses", 64'(abort_cnt - a0), 64'd1);
    chk("abort_idle", 64'(o_busy), 64'd0);
    xfer(2, 32'h3000_0000);

    // Reset during beat 2 of LEN=8 with nothing drained
    o_rdy = 1'b0;
    CHNL_RX = 1'b1; CHNL_RX_LEN = 32'd8; CHNL_RX_DATA_VALID = 1'b1;
    CHNL_RX_DATA = mk_beat(32'h4000_0000, 0);
    repeat (3) tick();
    CHNL_RX_DATA = mk_beat(32'h4000_0000, 1);
    rst_n = 1'b0; CHNL_RX = 1'b0; CHNL_RX_DATA_VALID = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_o_val", 64'(o_val), 64'd0);
    chk("midrst_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
    chk("midrst_ack", 64'(CHNL_RX_ACK), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    o_rdy = 1'b1;
    tick();
    xfer(2, 32'h5000_0000);

    repeat (3) tick();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("last_total", 64'(last_cnt), 64'd5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

endmodule
